// File: rtl/spi_slave_mode.sv
// -----------------------------------------------------------------------------
// spi_slave_mode
//
// This module is an SPI slave for the SoC host link. It supports a configurable
// word width and all four CPOL/CPHA modes. The mode is latched at the start of
// each frame. The module has a one-word TX holding buffer with underrun
// detection, and it emits frame start, end and error strobes. Everything runs
// on clk_i. The SPI pins are oversampled through synchroniser chains.
//
// Configuration macro: SPI_SLAVE_LSB_FIRST_EN
//   defined   - words travel LSB-first on MOSI and MISO
//   undefined - words travel MSB-first (default)
//
// Ports
//   clk_i, rst_i      system clock, synchronous active-high reset
//   spi_mode_i        {CPOL, CPHA}, sampled when CS_n falls
//   spi_sclk_i        SPI pin, asynchronous
//   spi_mosi_i        SPI pin, asynchronous
//   spi_cs_n_i        SPI pin, asynchronous
//   spi_miso_o        serial data out
//   spi_miso_oe_o     output enable, high while the frame is active
//   tx_data_i/tx_vld_i/tx_rdy_o   word hand-over into the TX holding buffer
//   rx_data_o/rx_vld_o            last received word, with a one-cycle pulse
//   frame_start_o, frame_end_o, frame_err_o, tx_underrun_o   one-cycle strobes
// -----------------------------------------------------------------------------
module spi_slave_mode #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] TX_IDLE     = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [1:0]            spi_mode_i,
    input  logic                  spi_sclk_i,
    input  logic                  spi_mosi_i,
    input  logic                  spi_cs_n_i,
    output logic                  spi_miso_o,
    output logic                  spi_miso_oe_o,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_vld_i,
    output logic                  tx_rdy_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_vld_o,
    output logic                  frame_start_o,
    output logic                  frame_end_o,
    output logic                  frame_err_o,
    output logic                  tx_underrun_o
);

    localparam int              CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] cs_n_sync_q, cs_n_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_n_prev_q, cs_n_prev_d;
    logic [1:0]             mode_q, mode_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]  rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0]  tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0]  tx_buf_q, tx_buf_d;
    logic                   tx_buf_full_q, tx_buf_full_d;
    logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
    logic                   rx_vld_q, rx_vld_d;
    logic                   frame_start_q, frame_start_d;
    logic                   frame_end_q, frame_end_d;
    logic                   frame_err_q, frame_err_d;
    logic                   tx_underrun_q, tx_underrun_d;

    logic sclk_s, mosi_s, cs_n_s;
    logic cs_fall, cs_rise, sclk_rise, sclk_fall;
    logic lead_edge, trail_edge, sample_edge, shift_edge;
    logic load_req, tx_accept;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk_i};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
        cs_n_sync_d = {cs_n_sync_q[SYNC_STAGES-2:0], spi_cs_n_i};
        sclk_s      = sclk_sync_q[SYNC_STAGES-1];
        mosi_s      = mosi_sync_q[SYNC_STAGES-1];
        cs_n_s      = cs_n_sync_q[SYNC_STAGES-1];
        sclk_prev_d = sclk_s;
        cs_n_prev_d = cs_n_s;

        cs_fall    = cs_n_prev_q & ~cs_n_s;
        cs_rise    = ~cs_n_prev_q & cs_n_s;
        sclk_rise  = ~sclk_prev_q & sclk_s;
        sclk_fall  = sclk_prev_q & ~sclk_s;
        lead_edge  = mode_q[1] ? sclk_fall : sclk_rise;
        trail_edge = mode_q[1] ? sclk_rise : sclk_fall;
        // On the CS_n falling edge, mode_q still holds the previous frame's
        // mode. Any SCLK edge in that cycle is therefore not trusted.
        sample_edge = ~cs_n_s & ~cs_fall & (mode_q[0] ? trail_edge : lead_edge);
        shift_edge  = ~cs_n_s & ~cs_fall & (mode_q[0] ? lead_edge : trail_edge);
        // In CPHA=0 the first bit must be on MISO before the first SCLK edge.
        // The word is therefore loaded at frame start. Otherwise every word is
        // loaded on the first shift edge of that word.
        load_req  = (cs_fall & ~spi_mode_i[0]) | (shift_edge & (bit_cnt_q == '0));
        tx_accept = tx_vld_i & ~tx_buf_full_q;

        mode_d        = mode_q;
        bit_cnt_d     = bit_cnt_q;
        rx_shift_d    = rx_shift_q;
        tx_shift_d    = tx_shift_q;
        tx_buf_d      = tx_buf_q;
        tx_buf_full_d = tx_buf_full_q;
        rx_data_d     = rx_data_q;
        rx_vld_d      = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        frame_err_d   = 1'b0;
        tx_underrun_d = 1'b0;

        if (cs_fall) begin
            mode_d        = spi_mode_i;
            bit_cnt_d     = '0;
            frame_start_d = 1'b1;
        end

        if (sample_edge) begin
`ifdef SPI_SLAVE_LSB_FIRST_EN
            rx_shift_d = {mosi_s, rx_shift_q[DATA_WIDTH-1:1]};
`else
            rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
`endif
            if (bit_cnt_q == CNT_LAST) begin
                bit_cnt_d = '0;
                rx_data_d = rx_shift_d;
                rx_vld_d  = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end

        if (shift_edge && (bit_cnt_q != '0)) begin
`ifdef SPI_SLAVE_LSB_FIRST_EN
            tx_shift_d = {1'b0, tx_shift_q[DATA_WIDTH-1:1]};
`else
            tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
`endif
        end

        if (load_req) begin
            if (tx_buf_full_q) begin
                tx_shift_d    = tx_buf_q;
                tx_buf_full_d = 1'b0;
            end else begin
                tx_shift_d    = TX_IDLE;
                tx_underrun_d = 1'b1;
            end
        end

        // Acceptance needs an empty buffer, so it never collides with a load
        // from a full buffer. An empty-buffer load (underrun) may still accept.
        if (tx_accept) begin
            tx_buf_d      = tx_data_i;
            tx_buf_full_d = 1'b1;
        end

        if (cs_rise) begin
            frame_end_d = 1'b1;
            frame_err_d = (bit_cnt_q != '0);
            bit_cnt_d   = '0;
            tx_shift_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_sync_q   <= '0;
            mosi_sync_q   <= '0;
            cs_n_sync_q   <= '1;
            sclk_prev_q   <= 1'b0;
            cs_n_prev_q   <= 1'b1;
            mode_q        <= 2'b00;
            bit_cnt_q     <= '0;
            rx_shift_q    <= '0;
            tx_shift_q    <= '0;
            tx_buf_q      <= '0;
            tx_buf_full_q <= 1'b0;
            rx_data_q     <= '0;
            rx_vld_q      <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            frame_err_q   <= 1'b0;
            tx_underrun_q <= 1'b0;
        end else begin
            sclk_sync_q   <= sclk_sync_d;
            mosi_sync_q   <= mosi_sync_d;
            cs_n_sync_q   <= cs_n_sync_d;
            sclk_prev_q   <= sclk_prev_d;
            cs_n_prev_q   <= cs_n_prev_d;
            mode_q        <= mode_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_shift_q    <= rx_shift_d;
            tx_shift_q    <= tx_shift_d;
            tx_buf_q      <= tx_buf_d;
            tx_buf_full_q <= tx_buf_full_d;
            rx_data_q     <= rx_data_d;
            rx_vld_q      <= rx_vld_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            frame_err_q   <= frame_err_d;
            tx_underrun_q <= tx_underrun_d;
        end
    end

`ifdef SPI_SLAVE_LSB_FIRST_EN
    assign spi_miso_o = tx_shift_q[0];
`else
    assign spi_miso_o = tx_shift_q[DATA_WIDTH-1];
`endif
    assign spi_miso_oe_o = ~cs_n_sync_q[SYNC_STAGES-1];
    assign tx_rdy_o      = ~tx_buf_full_q;
    assign rx_data_o     = rx_data_q;
    assign rx_vld_o      = rx_vld_q;
    assign frame_start_o = frame_start_q;
    assign frame_end_o   = frame_end_q;
    assign frame_err_o   = frame_err_q;
    assign tx_underrun_o = tx_underrun_q;

endmodule

// File: tb/tb_spi_slave_mode.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_mode
//
// This is a directed bench for spi_slave_mode. A bit-level SPI master model
// drives the pins, and a monitor counts the strobes. Expected words are written
// into the stimulus by hand. When SPI_SLAVE_LSB_FIRST_EN is defined, the bench
// switches to 16-bit words and LSB-first wire order.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_slave_mode;

`ifdef SPI_SLAVE_LSB_FIRST_EN
    localparam int W = 16;
`else
    localparam int W = 8;
`endif
    localparam int SYNC = 2;
    localparam int HALF = 8;   // clk cycles per SCLK half period

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic [1:0]   spi_mode_i = 2'b00;
    logic         spi_sclk_i = 1'b0;
    logic         spi_mosi_i = 1'b0;
    logic         spi_cs_n_i = 1'b1;
    logic         spi_miso_o, spi_miso_oe_o;
    logic [W-1:0] tx_data_i = '0;
    logic         tx_vld_i = 1'b0;
    logic         tx_rdy_o;
    logic [W-1:0] rx_data_o;
    logic         rx_vld_o, frame_start_o, frame_end_o, frame_err_o, tx_underrun_o;

    spi_slave_mode #(
        .DATA_WIDTH  (W),
        .SYNC_STAGES (SYNC),
        .TX_IDLE     (W'('h5A))
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .spi_mode_i    (spi_mode_i),
        .spi_sclk_i    (spi_sclk_i),
        .spi_mosi_i    (spi_mosi_i),
        .spi_cs_n_i    (spi_cs_n_i),
        .spi_miso_o    (spi_miso_o),
        .spi_miso_oe_o (spi_miso_oe_o),
        .tx_data_i     (tx_data_i),
        .tx_vld_i      (tx_vld_i),
        .tx_rdy_o      (tx_rdy_o),
        .rx_data_o     (rx_data_o),
        .rx_vld_o      (rx_vld_o),
        .frame_start_o (frame_start_o),
        .frame_end_o   (frame_end_o),
        .frame_err_o   (frame_err_o),
        .tx_underrun_o (tx_underrun_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // strobe monitor
    int n_rxv = 0, n_fs = 0, n_fe = 0, n_ferr = 0, n_both = 0, n_ur = 0;
    logic [W-1:0] rx_log [0:63];
    always @(negedge clk) begin
        if (rx_vld_o) begin
            rx_log[n_rxv % 64] = rx_data_o;
            n_rxv++;
        end
        if (frame_start_o) n_fs++;
        if (frame_end_o) n_fe++;
        if (frame_err_o) n_ferr++;
        if (frame_end_o && frame_err_o) n_both++;
        if (tx_underrun_o) n_ur++;
    end

    int b_rxv, b_fs, b_fe, b_ferr, b_both, b_ur;
    task automatic snap();
        b_rxv = n_rxv; b_fs = n_fs; b_fe = n_fe;
        b_ferr = n_ferr; b_both = n_both; b_ur = n_ur;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int bitpos(input int i);
`ifdef SPI_SLAVE_LSB_FIRST_EN
        return i;
`else
        return W - 1 - i;
`endif
    endfunction

    task automatic push_word(input logic [W-1:0] w);
        int t = 0;
        while (!tx_rdy_o && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) check_eq("push_wait_rdy", 32'(tx_rdy_o), 32'd1);
        tx_vld_i  = 1'b1;
        tx_data_i = w;
        @(negedge clk);
        tx_vld_i  = 1'b0;
    endtask

    // SPI master model: words from m_tx go out on MOSI, and MISO is captured
    // into m_rx. chg_at >= 0 flips spi_mode_i at that bit index.
    logic [W-1:0] m_tx [0:3];
    logic [W-1:0] m_rx [0:3];

    task automatic spi_frame(input logic [1:0] mode, input int nbits,
                             input int chg_at, input bit end_frame);
        for (int k = 0; k < 4; k++) m_rx[k] = '0;
        spi_mode_i = mode;
        spi_sclk_i = mode[1];
        clks(8);
        spi_cs_n_i = 1'b0;
        clks(10);
        for (int i = 0; i < nbits; i++) begin
            int w;
            int b;
            w = i / W;
            b = bitpos(i % W);
            if (i == chg_at) spi_mode_i = ~mode;
            if (!mode[0]) begin
                spi_mosi_i = m_tx[w][b];
                clks(HALF);
                m_rx[w][b] = spi_miso_o;
                spi_sclk_i = ~mode[1];
                clks(HALF);
                spi_sclk_i = mode[1];
            end else begin
                spi_sclk_i = ~mode[1];
                spi_mosi_i = m_tx[w][b];
                clks(HALF);
                m_rx[w][b] = spi_miso_o;
                spi_sclk_i = mode[1];
                clks(HALF);
            end
        end
        if (end_frame) begin
            clks(HALF);
            spi_cs_n_i = 1'b1;
            clks(12);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        clks(4);
        check_eq("rst_miso", 32'(spi_miso_o), 32'd0);
        check_eq("rst_oe", 32'(spi_miso_oe_o), 32'd0);
        check_eq("rst_rdy", 32'(tx_rdy_o), 32'd1);
        check_eq("rst_rx_data", 32'(rx_data_o), 32'd0);
        check_eq("rst_strobes", 32'({rx_vld_o, frame_start_o, frame_end_o,
                                     frame_err_o, tx_underrun_o}), 32'd0);
        rst_i = 1'b0;
        clks(6);

        // one word in each mode; modes 2 and 3 flip spi_mode_i mid-frame
        for (int md = 0; md < 4; md++) begin
            logic [1:0] ml;
            ml = 2'(md);
            push_word(W'('hA5));
            check_eq($sformatf("m%0d_rdy_full", md), 32'(tx_rdy_o), 32'd0);
            snap();
            m_tx[0] = W'('h3C);
            spi_frame(ml, W, (md >= 2) ? 3 : -1, 1'b1);
            check_eq($sformatf("m%0d_rx_data", md), 32'(rx_data_o), 32'h3C);
            check_eq($sformatf("m%0d_rx_vld_cnt", md), 32'(n_rxv - b_rxv), 32'd1);
            check_eq($sformatf("m%0d_miso_word", md), 32'(m_rx[0]), 32'hA5);
            check_eq($sformatf("m%0d_start_cnt", md), 32'(n_fs - b_fs), 32'd1);
            check_eq($sformatf("m%0d_end_cnt", md), 32'(n_fe - b_fe), 32'd1);
            check_eq($sformatf("m%0d_err_cnt", md), 32'(n_ferr - b_ferr), 32'd0);
            // CPHA=0 loads again on the final trailing edge, and the buffer is empty then
            check_eq($sformatf("m%0d_ur_cnt", md), 32'(n_ur - b_ur), ml[0] ? 32'd0 : 32'd1);
        end

        // three back-to-back words in mode 0; the fourth push covers the
        // closing CPHA=0 load
        push_word(W'('h11));
        snap();
        m_tx[0] = W'('h01); m_tx[1] = W'('h02); m_tx[2] = W'('h03);
        fork
            spi_frame(2'b00, 3 * W, -1, 1'b1);
            begin
                push_word(W'('h22));
                push_word(W'('h33));
                push_word(W'('h44));
            end
        join
        check_eq("b2b_rx_vld_cnt", 32'(n_rxv - b_rxv), 32'd3);
        check_eq("b2b_rx0", 32'(rx_log[(b_rxv + 0) % 64]), 32'h01);
        check_eq("b2b_rx1", 32'(rx_log[(b_rxv + 1) % 64]), 32'h02);
        check_eq("b2b_rx2", 32'(rx_log[(b_rxv + 2) % 64]), 32'h03);
        check_eq("b2b_miso0", 32'(m_rx[0]), 32'h11);
        check_eq("b2b_miso1", 32'(m_rx[1]), 32'h22);
        check_eq("b2b_miso2", 32'(m_rx[2]), 32'h33);
        check_eq("b2b_ur_cnt", 32'(n_ur - b_ur), 32'd0);
        check_eq("b2b_rdy_after", 32'(tx_rdy_o), 32'd1);

        // underrun at the frame-start load, with tx_vld_i in the same cycle
        check_eq("ur_rdy_before", 32'(tx_rdy_o), 32'd1);
        snap();
        m_tx[0] = W'('h96);
        fork
            spi_frame(2'b00, W, -1, 1'b1);
            begin
                clks(8 + SYNC);
                tx_vld_i  = 1'b1;
                tx_data_i = W'('h77);
                clks(1);
                tx_vld_i  = 1'b0;
                check_eq("ur_accept_rdy", 32'(tx_rdy_o), 32'd0);
            end
        join
        check_eq("ur_miso_word", 32'(m_rx[0]), 32'h5A);
        check_eq("ur_cnt", 32'(n_ur - b_ur), 32'd1);
        check_eq("ur_rx_data", 32'(rx_data_o), 32'h96);
        check_eq("ur_rdy_after", 32'(tx_rdy_o), 32'd1);

        // CS deasserted after 5 bits
        snap();
        m_tx[0] = W'('hFF);
        spi_frame(2'b00, 5, -1, 1'b1);
        check_eq("abort_end_err_together", 32'(n_both - b_both), 32'd1);
        check_eq("abort_end_cnt", 32'(n_fe - b_fe), 32'd1);
        check_eq("abort_err_cnt", 32'(n_ferr - b_ferr), 32'd1);
        check_eq("abort_rx_vld_cnt", 32'(n_rxv - b_rxv), 32'd0);
        check_eq("abort_rx_hold", 32'(rx_data_o), 32'h96);
        push_word(W'('h5C));
        snap();
        m_tx[0] = W'('hC3);
        spi_frame(2'b00, W, -1, 1'b1);
        check_eq("post_abort_rx", 32'(rx_data_o), 32'hC3);
        check_eq("post_abort_miso", 32'(m_rx[0]), 32'h5C);
        check_eq("post_abort_err_cnt", 32'(n_ferr - b_ferr), 32'd0);

        // reset in mid-word
        push_word(W'('hE7));
        snap();
        m_tx[0] = W'('h55);
        spi_frame(2'b01, 3, -1, 1'b0);
        push_word(W'('h99));
        check_eq("midrst_rdy_before", 32'(tx_rdy_o), 32'd0);
        check_eq("midrst_oe_before", 32'(spi_miso_oe_o), 32'd1);
        rst_i = 1'b1;
        clks(2);
        check_eq("midrst_miso", 32'(spi_miso_o), 32'd0);
        check_eq("midrst_oe", 32'(spi_miso_oe_o), 32'd0);
        check_eq("midrst_rdy", 32'(tx_rdy_o), 32'd1);
        check_eq("midrst_rx_data", 32'(rx_data_o), 32'd0);
        check_eq("midrst_strobes", 32'({rx_vld_o, frame_start_o, frame_end_o,
                                        frame_err_o, tx_underrun_o}), 32'd0);
        spi_cs_n_i = 1'b1;
        spi_sclk_i = 1'b0;
        clks(2);
        rst_i = 1'b0;
        clks(10);
        check_eq("midrst_no_end", 32'(n_fe - b_fe), 32'd0);
        check_eq("midrst_start_cnt", 32'(n_fs - b_fs), 32'd1);

        // clean mode-3 frame after the reset
        push_word(W'('h6B));
        snap();
        m_tx[0] = W'('hD2);
        spi_frame(2'b11, W, -1, 1'b1);
        check_eq("m3_post_rst_rx", 32'(rx_data_o), 32'hD2);
        check_eq("m3_post_rst_miso", 32'(m_rx[0]), 32'h6B);
        check_eq("m3_post_rst_vld_cnt", 32'(n_rxv - b_rxv), 32'd1);

`ifdef SPI_SLAVE_LSB_FIRST_EN
        // full-width word with both end bits set
        push_word(W'('h4003));
        m_tx[0] = W'('h8001);
        spi_frame(2'b00, W, -1, 1'b1);
        check_eq("lsb_rx", 32'(rx_data_o), 32'h8001);
        check_eq("lsb_miso", 32'(m_rx[0]), 32'h4003);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_slave_mode.md
# spi_slave_mode

Parametrised SPI slave for the SoC host link: configurable word width, all four CPOL/CPHA modes selected per frame, an input synchroniser, a one-word TX holding buffer with underrun detection, and frame start, end and error strobes. It sits between the external SPI pins and the command/data path. It receives MOSI words into `rx_data_o` and transmits words handed over on a valid/ready port. All logic runs in the `clk_i` domain; the SPI pins are sampled asynchronously.

## Interface
- `DATA_WIDTH`, default 8: bits per SPI word; must be ≥ 2.
- `SYNC_STAGES`, default 2: synchroniser flops on `spi_sclk_i`, `spi_mosi_i` and `spi_cs_n_i`; must be ≥ 2.
- `TX_IDLE`, default 0: word shifted out on TX underrun; `DATA_WIDTH` bits wide.
- `clk_i`  in  1  system clock; the block's only clock.
- `rst_i`  in  1  reset, synchronous and active-high.
- `spi_mode_i`  in  2  SPI mode: bit 1 is CPOL, bit 0 is CPHA. Latched at the start of each frame.
- `spi_sclk_i`  in  1  SPI clock, asynchronous.
- `spi_mosi_i`  in  1  SPI data in, asynchronous.
- `spi_cs_n_i`  in  1  chip select, active-low, asynchronous.
- `spi_miso_o`  out  1  SPI data out; equals `tx_shift[DATA_WIDTH-1]`.
- `spi_miso_oe_o`  out  1  MISO output enable; high while the frame is active.
- `tx_data_i`  in  `DATA_WIDTH`  word to transmit.
- `tx_vld_i`  in  1  `tx_data_i` is valid.
- `tx_rdy_o`  out  1  TX holding buffer is empty.
- `rx_data_o`  out  `DATA_WIDTH`  last received word; held until the next word completes.
- `rx_vld_o`  out  1  one-cycle pulse when `rx_data_o` updates.
- `frame_start_o`  out  1  one-cycle pulse on synchronised CS assertion.
- `frame_end_o`  out  1  one-cycle pulse on synchronised CS deassertion.
- `frame_err_o`  out  1  one-cycle pulse when CS deasserts mid-word.
- `tx_underrun_o`  out  1  one-cycle pulse when `TX_IDLE` is loaded because the buffer was empty.

## Operation
- **Synchroniser and edge detect:** SCLK, MOSI and CS_n each pass through `SYNC_STAGES` flops. One further register detects edges. Frame active = synchronised CS_n low.
- **Frame start:** on the falling edge of synchronised CS_n:
  - latch `spi_mode_i`;
  - clear `bit_cnt`;
  - pulse `frame_start_o`;
  - if CPHA=0, load `tx_shift` (see load rule).
- **Edge roles:**
  - Leading edge = rising if CPOL=0, falling if CPOL=1.
  - Sample edge = leading edge if CPHA=0, trailing edge if CPHA=1.
  - Shift edge = the other edge.
  - SCLK edges while the frame is inactive are ignored.
- **Sample edge:**
  - `rx_shift` takes the synchronised MOSI.
  - `bit_cnt` increments and wraps at `DATA_WIDTH`.
  - On wrap, `rx_data_o` ← completed word and `rx_vld_o` pulses the next cycle.
- **Shift edge:**
  - If `bit_cnt` = 0, load `tx_shift`.
  - Otherwise shift `tx_shift` toward the output by one bit.
- **Load rule:**
  - If `tx_buf` is full, `tx_shift` ← `tx_buf` and `tx_buf` is emptied.
  - If `tx_buf` is empty, `tx_shift` ← `TX_IDLE` and `tx_underrun_o` pulses.
- **TX handshake:**
  - A transfer occurs when `tx_vld_i` & `tx_rdy_o`; `tx_buf` is written the next cycle.
  - `tx_rdy_o` = !`tx_buf_full`.
  - Load and accept in the same cycle with the buffer empty: `TX_IDLE` is loaded (underrun) and the new word is still accepted into `tx_buf`.
- **CPHA=0 end of frame:** the final trailing edge loads the next word, consuming `tx_buf`. That word is discarded at frame end; this is required behaviour.
- **Frame end:** on the rising edge of synchronised CS_n:
  - pulse `frame_end_o`;
  - also pulse `frame_err_o` if `bit_cnt` ≠ 0; the partial word is dropped and `rx_vld_o` does not fire;
  - clear `bit_cnt` and `tx_shift`.
- **Mode changes:** `spi_mode_i` changes during a frame are ignored until the next frame start.
- **Reset:**
  - Clears the synchroniser chains to the idle level (CS_n = 1).
  - Clears `bit_cnt`, `rx_shift`, `tx_shift`, `tx_buf_full` and all pulses.
  - Reset in mid-frame aborts the frame with no `frame_end_o`.
  - Output reset values: `spi_miso_o`=0, `spi_miso_oe_o`=0, `tx_rdy_o`=1, `rx_data_o`=0, `rx_vld_o`=0, `frame_start_o`=0, `frame_end_o`=0, `frame_err_o`=0, `tx_underrun_o`=0.

## Timing
- Pin edge to internal edge event: `SYNC_STAGES`+1 cycles.
- `rx_vld_o`: one cycle after the internal last-sample-edge event.
- `spi_miso_o` updates one cycle after the internal shift-edge event.
- `spi_miso_oe_o` follows synchronised CS_n with no extra delay.
- `clk_i` must be ≥ 8× the SCLK frequency.
- CS_n assertion to first SCLK edge must be ≥ `SYNC_STAGES`+3 `clk_i` cycles, so that the CPHA=0 load completes.
- Back-to-back words: `tx_buf` must be written before the next load edge to avoid underrun.

## Configuration
- Macro `SPI_SLAVE_LSB_FIRST_EN`:
  - Defined: words are shifted LSB-first on both MOSI and MISO; `spi_miso_o` = `tx_shift[0]` and `rx_shift` fills from the MSB end.
  - Undefined (default): MSB-first.
  - Counting, handshakes and timing are identical in both cases.

## Test plan
- Mode 0, `DATA_WIDTH`=8, `tx_buf`=0xA5 preloaded; master sends 0x3C → `rx_data_o`=0x3C with one `rx_vld_o` pulse; master captures 0xA5; `frame_start_o`/`frame_end_o` each pulse once.
- Modes 1, 2, 3 each: same exchange → identical `rx_data_o` and MISO data; mode change applied mid-frame has no effect until the next CS assertion.
- Three back-to-back words 0x01, 0x02, 0x03 with `tx_buf` refilled as soon as `tx_rdy_o` rises → three `rx_vld_o` pulses, no `tx_underrun_o`.
- `tx_buf` empty at a load edge, `TX_IDLE`=0x5A → master receives 0x5A; `tx_underrun_o` pulses once; `tx_vld_i` in the same cycle is accepted.
- CS deasserted after 5 bits → `frame_err_o` and `frame_end_o` pulse together; no `rx_vld_o`; next frame receives its full word correctly. `rst_i` mid-word → all outputs return to reset values.
- `DATA_WIDTH`=16 with `SPI_SLAVE_LSB_FIRST_EN` defined; send 0x8001 → bit order on the wire is LSB-first and `rx_data_o`=0x8001.
